shifter_universal: RTL and testbench

- Parametrised successor to the fixed 8-bit free-running shifter.
- Adds a configurable width, a reset pattern, an 8-operation mode set, parallel load and a serial in/out.
- Also adds a burst engine that repeats one operation a programmed number of times, with a busy/done handshake.
- It is the shift/rotate datapath element for the lab display and pattern-generator blocks.

---
 rtl/shifter_universal.sv | 139 +++++++++++++
 tb/tb_shifter_universal.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_universal.sv
// Universal shift/rotate register: immediate mode operations in IDLE,
// plus a burst engine that repeats one latched operation a programmed number of times.
module shifter_universal #(
    parameter int                   BIT_WIDTH = 8,
    parameter int                   AMT_WIDTH = 4,
    parameter logic [BIT_WIDTH-1:0] RST_VAL   = 8'b0000_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2:0]           mode,
    input  logic [BIT_WIDTH-1:0] load_data,
    input  logic                 ser_in,
    input  logic                 start,
    input  logic [AMT_WIDTH-1:0] amount,
    output logic [BIT_WIDTH-1:0] q,
    output logic                 ser_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_JOHN = 3'b111
    } op_t;

    state_t                 state, state_next;
    logic [AMT_WIDTH-1:0]   count, count_next;
    logic [2:0]             lat_mode, lat_mode_next;
    logic [BIT_WIDTH-1:0]   q_next;
    logic                   ser_out_next;
    logic                   do_op;
    logic [2:0]             op_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            lat_mode <= M_HOLD;
            q        <= RST_VAL;
            ser_out  <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            lat_mode <= lat_mode_next;
            q        <= q_next;
            ser_out  <= ser_out_next;
        end
    end

    // Sequencing: decide whether an operation happens this edge and which one.
    // A start in IDLE only arms the burst; the first operation is on the following edge.
    always_comb begin
        state_next    = state;
        count_next    = count;
        lat_mode_next = lat_mode;
        do_op         = 1'b0;
        op_mode       = mode;
        unique case (state)
            IDLE: begin
                if (start) begin
                    lat_mode_next = mode;
                    count_next    = amount;
                    state_next    = (amount != '0) ? RUN : DONE;
                end else if (en) begin
                    do_op   = 1'b1;
                    op_mode = mode;
                end
            end
            RUN: begin
                do_op      = 1'b1;
                op_mode    = lat_mode;
                count_next = count - 1'b1;
                if (count == {{(AMT_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: HOLD and LOAD leave ser_out alone; all shifting modes report the bit that left.
    always_comb begin
        q_next       = q;
        ser_out_next = ser_out;
        if (do_op) begin
            unique case (op_mode)
                M_HOLD: q_next = q;
                M_LOAD: q_next = load_data;
                M_SHL: begin
                    q_next       = {q[BIT_WIDTH-2:0], ser_in};
                    ser_out_next = q[BIT_WIDTH-1];
                end
                M_SHR: begin
                    q_next       = {ser_in, q[BIT_WIDTH-1:1]};
                    ser_out_next = q[0];
                end
                M_ROL: begin
                    q_next       = {q[BIT_WIDTH-2:0], q[BIT_WIDTH-1]};
                    ser_out_next = q[BIT_WIDTH-1];
                end
                M_ROR: begin
                    q_next       = {q[0], q[BIT_WIDTH-1:1]};
                    ser_out_next = q[0];
                end
                M_ASR: begin
                    q_next       = {q[BIT_WIDTH-1], q[BIT_WIDTH-1:1]};
                    ser_out_next = q[0];
                end
                M_JOHN: begin
                    q_next       = {q[BIT_WIDTH-2:0], ~q[BIT_WIDTH-1]};
                    ser_out_next = q[BIT_WIDTH-1];
                end
                default: q_next = q;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shifter_universal.sv
// Directed self-checking bench for shifter_universal at default parameters.
module tb_shifter_universal;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] load_data;
    logic       ser_in;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    shifter_universal dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .load_data (load_data),
        .ser_in    (ser_in),
        .start     (start),
        .amount    (amount),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        rst_n = 1'b0; en = 1'b0; mode = 3'b000; load_data = 8'h00;
        ser_in = 1'b0; start = 1'b0; amount = 4'd0;
        #12;
        exp_v = {8'h01, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if ({q, ser_out, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset {q,ser,busy,done} got=%h exp=%h", {q, ser_out, busy, done}, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rol_walk();
        logic [7:0] walk [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        en = 1'b1; mode = 3'b100;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (q !== walk[i]) begin
                n_fail++;
                $display("[TB] FAIL rol_walk[%0d] q got=%h exp=%h", i, q, walk[i]);
            end
        end
        n_checks++;
        if (ser_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rol_walk ser_out got=%b exp=1", ser_out);
        end
        en = 1'b0;
    endtask

    task automatic test_immediate_ops();
        logic [8:0] exp_v;
        en = 1'b1; mode = 3'b001; load_data = 8'hB4;
        tick();
        n_checks++;
        if (q !== 8'hB4) begin
            n_fail++;
            $display("[TB] FAIL load q got=%h exp=b4", q);
        end
        mode = 3'b110;
        tick();
        exp_v = {8'hDA, 1'b0};
        n_checks++;
        if ({q, ser_out} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL asr1 {q,ser} got=%h exp=%h", {q, ser_out}, exp_v);
        end
        tick();
        exp_v = {8'hED, 1'b0};
        n_checks++;
        if ({q, ser_out} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL asr2 {q,ser} got=%h exp=%h", {q, ser_out}, exp_v);
        end
        mode = 3'b011; ser_in = 1'b0;
        tick();
        exp_v = {8'h76, 1'b1};
        n_checks++;
        if ({q, ser_out} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL shr {q,ser} got=%h exp=%h", {q, ser_out}, exp_v);
        end
        en = 1'b0;
    endtask

    task automatic test_ror_burst();
        logic [10:0] exp_seq [5] = '{
            {8'h81, 1'b1, 1'b1, 1'b0},
            {8'hC0, 1'b1, 1'b1, 1'b0},
            {8'h60, 1'b0, 1'b1, 1'b0},
            {8'h30, 1'b0, 1'b0, 1'b1},
            {8'h30, 1'b0, 1'b0, 1'b0}
        };
        en = 1'b1; mode = 3'b001; load_data = 8'h81;
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b101; amount = 4'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if ({q, ser_out, busy, done} !== exp_seq[i]) begin
                n_fail++;
                $display("[TB] FAIL ror_burst[%0d] {q,ser,busy,done} got=%h exp=%h",
                         i, {q, ser_out, busy, done}, exp_seq[i]);
            end
        end
    endtask

    task automatic test_zero_amount();
        logic [9:0] exp_v;
        start = 1'b1; mode = 3'b100; amount = 4'd0;
        tick();
        start = 1'b0;
        exp_v = {8'h30, 1'b0, 1'b1};
        n_checks++;
        if ({q, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL zero_amt {q,busy,done} got=%h exp=%h", {q, busy, done}, exp_v);
        end
        tick();
        exp_v = {8'h30, 1'b0, 1'b0};
        n_checks++;
        if ({q, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL zero_amt_end {q,busy,done} got=%h exp=%h", {q, busy, done}, exp_v);
        end
        start = 1'b1; en = 1'b1; mode = 3'b001; load_data = 8'hAA; amount = 4'd0;
        tick();
        start = 1'b0; en = 1'b0;
        exp_v = {8'h30, 1'b0, 1'b1};
        n_checks++;
        if ({q, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL start_beats_en {q,busy,done} got=%h exp=%h", {q, busy, done}, exp_v);
        end
        tick();
    endtask

    task automatic test_john_burst();
        logic [7:0] seq [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        logic [9:0] exp_v;
        en = 1'b1; mode = 3'b001; load_data = 8'h00;
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b111; amount = 4'd15;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 5) begin
                start = 1'b1; en = 1'b1; mode = 3'b001; load_data = 8'h55; amount = 4'd2;
            end else begin
                start = 1'b0; en = 1'b0;
            end
            tick();
            exp_v = {seq[i], (i != 14), (i == 14)};
            n_checks++;
            if ({q, busy, done} !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL john[%0d] {q,busy,done} got=%h exp=%h", i, {q, busy, done}, exp_v);
            end
        end
        n_checks++;
        if (ser_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL john ser_out got=%b exp=1", ser_out);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL john_end {busy,done} got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [10:0] exp_v;
        logic        saw_done;
        start = 1'b1; mode = 3'b100; amount = 4'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        exp_v = {8'h04, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if ({q, ser_out, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL pre_abort {q,ser,busy,done} got=%h exp=%h", {q, ser_out, busy, done}, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {8'h01, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if ({q, ser_out, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL async_abort {q,ser,busy,done} got=%h exp=%h", {q, ser_out, busy, done}, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if ({saw_done, q} !== {1'b0, 8'h01}) begin
            n_fail++;
            $display("[TB] FAIL post_abort {activity,q} got=%h exp=%h", {saw_done, q}, {1'b0, 8'h01});
        end
        start = 1'b1; mode = 3'b010; ser_in = 1'b1; amount = 4'd2;
        tick();
        start = 1'b0;
        tick();
        exp_v = {8'h03, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if ({q, ser_out, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reburst1 {q,ser,busy,done} got=%h exp=%h", {q, ser_out, busy, done}, exp_v);
        end
        tick();
        exp_v = {8'h07, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({q, ser_out, busy, done} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reburst2 {q,ser,busy,done} got=%h exp=%h", {q, ser_out, busy, done}, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_rol_walk();
        test_immediate_ops();
        test_ror_burst();
        test_zero_amount();
        test_john_burst();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
